// File: rtl/glip_pattern_pkg.sv
// ============================================================================
// Module      : glip_pattern_pkg
// Description : Shared types and constants for the GLIP incrementing-pattern
//               checker (FSM states, default widths, pattern step).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package glip_pattern_pkg;

  // Checker FSM: waiting for enable, waiting for first word, checking.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH         = 8;
  localparam int DEFAULT_BYTECNT_WIDTH = 32;
  localparam int DEFAULT_ERRCNT_WIDTH  = 16;
  localparam int DEFAULT_STALL_PERIOD  = 4;

  // The host generator sends value n followed by n + PATTERN_STEP.
  localparam int PATTERN_STEP = 1;

endpackage : glip_pattern_pkg

`default_nettype wire

// File: rtl/glip_sat_counter.sv
// ============================================================================
// Module      : glip_sat_counter
// Description : Up-counter that sticks at all-ones; synchronous clear has
//               priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module glip_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // Clear wins; otherwise count up until every bit is set, then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule : glip_sat_counter

`default_nettype wire

// File: rtl/glip_pattern_checker.sv
// ============================================================================
// Module      : glip_pattern_checker
// Description : Receiving end of the GLIP host pattern generator. Locks onto
//               the first word of the FIFO-in stream, then checks that each
//               following word is the previous one plus one. Counts accepted
//               words and mismatches and captures the first mismatch.
//               Optional macro GLIP_PATTERN_CHECKER_STALL_EN adds periodic
//               backpressure (in_ready low 1 of every STALL_PERIOD cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module glip_pattern_checker
  import glip_pattern_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int BYTECNT_WIDTH = DEFAULT_BYTECNT_WIDTH,
  parameter int ERRCNT_WIDTH  = DEFAULT_ERRCNT_WIDTH,
  parameter int STALL_PERIOD  = DEFAULT_STALL_PERIOD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic [WIDTH-1:0]         in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic                     synced_o,
  output logic                     error_o,
  output logic [ERRCNT_WIDTH-1:0]  error_count_o,
  output logic [BYTECNT_WIDTH-1:0] byte_count_o,
  output logic                     first_err_valid_o,
  output logic [WIDTH-1:0]         first_err_expected_o,
  output logic [WIDTH-1:0]         first_err_received_o
);

  // A stall period below 2 would hold in_ready low permanently.
  if (STALL_PERIOD < 2) begin : g_bad_stall_period
    $error("glip_pattern_checker: STALL_PERIOD must be >= 2");
  end

  localparam logic [WIDTH-1:0] c_step = WIDTH'(PATTERN_STEP);

  state_e                   state_q, state_d;
  logic [WIDTH-1:0]         expected_q, expected_d;
  logic [BYTECNT_WIDTH-1:0] byte_count_q, byte_count_d;
  logic                     error_q;
  logic                     fe_valid_q, fe_valid_d;
  logic [WIDTH-1:0]         fe_expected_q, fe_expected_d;
  logic [WIDTH-1:0]         fe_received_q, fe_received_d;

  logic w_active;
  logic w_stall_ok;
  logic w_xfer;
  logic w_start;
  logic w_mismatch;

`ifdef GLIP_PATTERN_CHECKER_STALL_EN
  localparam int c_stall_cw = $clog2(STALL_PERIOD);

  logic [c_stall_cw-1:0] stall_cnt_q;

  // Free-running modulo-STALL_PERIOD counter; only rst restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_q == c_stall_cw'(STALL_PERIOD - 1)) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign w_stall_ok = (stall_cnt_q != '0);
`else
  assign w_stall_ok = 1'b1;
`endif

  // in_ready is a decode of registered state only, never of in_valid.
  assign w_active   = (state_q != IDLE);
  assign in_ready_o = w_active & w_stall_ok;
  assign w_xfer     = in_valid_i & in_ready_o;
  assign w_start    = (state_q == IDLE) & enable_i;
  assign w_mismatch = w_xfer & (state_q == CHECK) & (in_data_i != expected_q);

  // Next-state and datapath update for the checker.
  always_comb begin
    state_d       = state_q;
    expected_d    = expected_q;
    byte_count_d  = byte_count_q;
    fe_valid_d    = fe_valid_q;
    fe_expected_d = fe_expected_q;
    fe_received_d = fe_received_q;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d       = SYNC;
          byte_count_d  = '0;
          fe_valid_d    = 1'b0;
          fe_expected_d = '0;
          fe_received_d = '0;
        end
      end

      SYNC: begin
        // The first word only seeds the expectation; it is never compared.
        if (w_xfer) begin
          expected_d   = in_data_i + c_step;
          byte_count_d = BYTECNT_WIDTH'(1);
          state_d      = CHECK;
        end
        if (!enable_i) begin
          state_d = IDLE;
        end
      end

      CHECK: begin
        if (w_xfer) begin
          byte_count_d = byte_count_q + 1'b1;
          // On a mismatch, resynchronise on what was actually received.
          expected_d   = in_data_i + c_step;
          if (w_mismatch && !fe_valid_q) begin
            fe_valid_d    = 1'b1;
            fe_expected_d = expected_q;
            fe_received_d = in_data_i;
          end
        end
        if (!enable_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      expected_q    <= '0;
      byte_count_q  <= '0;
      error_q       <= 1'b0;
      fe_valid_q    <= 1'b0;
      fe_expected_q <= '0;
      fe_received_q <= '0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      byte_count_q  <= byte_count_d;
      error_q       <= w_mismatch;
      fe_valid_q    <= fe_valid_d;
      fe_expected_q <= fe_expected_d;
      fe_received_q <= fe_received_d;
    end
  end

  glip_sat_counter #(
    .WIDTH (ERRCNT_WIDTH)
  ) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (w_start),
    .inc_i   (w_mismatch),
    .count_o (error_count_o)
  );

  assign synced_o             = (state_q == CHECK);
  assign error_o              = error_q;
  assign byte_count_o         = byte_count_q;
  assign first_err_valid_o    = fe_valid_q;
  assign first_err_expected_o = fe_expected_q;
  assign first_err_received_o = fe_received_q;

endmodule : glip_pattern_checker

`default_nettype wire

// File: tb/tb_glip_pattern_checker.sv
// ============================================================================
// Module      : tb_glip_pattern_checker
// Description : Self-checking bench for glip_pattern_checker. A small
//               behavioural model predicts every output after every clock.
//               Honours GLIP_PATTERN_CHECKER_STALL_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_glip_pattern_checker;

  localparam int W   = 8;
  localparam int BCW = 32;
  localparam int ECW = 2;
  localparam int SP  = 4;
  localparam int EC_MAX = (1 << ECW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic           synced;
  logic           error;
  logic [ECW-1:0] error_count;
  logic [BCW-1:0] byte_count;
  logic           fe_valid;
  logic [W-1:0]   fe_expected;
  logic [W-1:0]   fe_received;

  glip_pattern_checker #(
    .WIDTH         (W),
    .BYTECNT_WIDTH (BCW),
    .ERRCNT_WIDTH  (ECW),
    .STALL_PERIOD  (SP)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable_i             (enable),
    .in_data_i            (in_data),
    .in_valid_i           (in_valid),
    .in_ready_o           (in_ready),
    .synced_o             (synced),
    .error_o              (error),
    .error_count_o        (error_count),
    .byte_count_o         (byte_count),
    .first_err_valid_o    (fe_valid),
    .first_err_expected_o (fe_expected),
    .first_err_received_o (fe_received)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int obs_pulses = 0;

  // Behavioural model state.
  bit           m_active;
  bit           m_locked;
  logic [W-1:0] m_exp;
  int unsigned  m_bc;
  int           m_ec;
  bit           m_err;
  bit           m_fev;
  logic [W-1:0] m_fee;
  logic [W-1:0] m_fer;
  int           m_edges;

  function automatic bit model_ready();
`ifdef GLIP_PATTERN_CHECKER_STALL_EN
    return m_active && ((m_edges % SP) != 0);
`else
    return m_active;
`endif
  endfunction

  function automatic void model_reset();
    m_active = 0; m_locked = 0; m_exp = '0; m_bc = 0; m_ec = 0;
    m_err = 0; m_fev = 0; m_fee = '0; m_fer = '0; m_edges = 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".in_ready"},    32'(in_ready),    32'(model_ready()));
    check({ctx, ".synced"},      32'(synced),      32'(m_locked));
    check({ctx, ".error"},       32'(error),       32'(m_err));
    check({ctx, ".error_count"}, 32'(error_count), 32'(m_ec));
    check({ctx, ".byte_count"},  byte_count,       m_bc);
    check({ctx, ".fe_valid"},    32'(fe_valid),    32'(m_fev));
    check({ctx, ".fe_expected"}, 32'(fe_expected), 32'(m_fee));
    check({ctx, ".fe_received"}, 32'(fe_received), 32'(m_fer));
  endtask

  // One clock: apply inputs, advance model at the edge, compare #1 later.
  task automatic step(input bit en, input bit v, input logic [W-1:0] d, input string ctx);
    bit xf;
    enable = en; in_valid = v; in_data = d;
    xf = v && model_ready();
    @(posedge clk);
    m_err = 0;
    if (!m_active) begin
      if (en) begin
        m_active = 1; m_locked = 0; m_bc = 0; m_ec = 0;
        m_fev = 0; m_fee = '0; m_fer = '0;
      end
    end else begin
      if (xf) begin
        if (!m_locked) begin
          m_bc = 1; m_locked = 1;
        end else begin
          m_bc++;
          if (d != m_exp) begin
            m_err = 1;
            if (m_ec < EC_MAX) m_ec++;
            if (!m_fev) begin m_fev = 1; m_fee = m_exp; m_fer = d; end
          end
        end
        m_exp = d + 8'd1;
      end
      if (!en) begin m_active = 0; m_locked = 0; end
    end
    m_edges++;
    #1;
    if (error === 1'b1) obs_pulses++;
    check_all(ctx);
  endtask

  // Offer a word until it is accepted, with a bounded number of tries.
  task automatic send(input logic [W-1:0] d, input string ctx);
    bit done = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      done = model_ready();
      step(1'b1, 1'b1, d, ctx);
    end
    check({ctx, ".send_bound"}, 32'(done), 32'd1);
  endtask

  task automatic restart();
    step(1'b0, 1'b0, '0, "stop");
    step(1'b1, 1'b0, '0, "start");
  endtask

  initial begin
    int unsigned bc0;
    int p0;
    logic [W-1:0] d;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all("reset");

    // Clean stream 0x10..0x1F.
    step(1'b1, 1'b0, '0, "start");
    p0 = obs_pulses;
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), "clean");
    check("clean.bc16",   byte_count, 32'd16);
    check("clean.ec0",    32'(error_count), 32'd0);
    check("clean.synced", 32'(synced), 32'd1);
    check("clean.pulses", 32'(obs_pulses - p0), 32'd0);

    // Wrap 0xFD..0x01.
    restart();
    p0 = obs_pulses;
    for (int i = 0; i < 5; i++) send(8'(8'hFD + i), "wrap");
    check("wrap.bc5",   byte_count, 32'd5);
    check("wrap.ec0",   32'(error_count), 32'd0);
    check("wrap.pulses", 32'(obs_pulses - p0), 32'd0);

    // Single corruption.
    restart();
    p0 = obs_pulses;
    send(8'h00, "corrupt"); send(8'h01, "corrupt"); send(8'h55, "corrupt");
    send(8'h56, "corrupt"); send(8'h57, "corrupt");
    step(1'b1, 1'b0, '0, "corrupt.idle");
    check("corrupt.ec1",    32'(error_count), 32'd1);
    check("corrupt.fee",    32'(fe_expected), 32'h02);
    check("corrupt.fer",    32'(fe_received), 32'h55);
    check("corrupt.pulses", 32'(obs_pulses - p0), 32'd1);

    // Saturation: five mismatches into a 2-bit counter.
    restart();
    p0 = obs_pulses;
    send(8'h00, "sat");
    for (int i = 1; i <= 5; i++) send(8'(i * 16), "sat");
    step(1'b1, 1'b0, '0, "sat.idle");
    check("sat.ec3",    32'(error_count), 32'd3);
    check("sat.pulses", 32'(obs_pulses - p0), 32'd5);
    check("sat.fee",    32'(fe_expected), 32'h01);
    check("sat.fer",    32'(fe_received), 32'h10);

    // Disable mid-stream and restart.
    restart();
    send(8'h20, "dis"); send(8'h21, "dis"); send(8'h22, "dis");
    step(1'b0, 1'b0, '0, "dis.off");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h99, "dis.hold");
    check("dis.ready0", 32'(in_ready), 32'd0);
    check("dis.bc3",    byte_count, 32'd3);
    step(1'b1, 1'b0, '0, "dis.on");
    check("dis.bc_clr", byte_count, 32'd0);
    send(8'h80, "dis.resync"); send(8'h81, "dis.resync");
    check("dis.bc2",  byte_count, 32'd2);
    check("dis.ec0",  32'(error_count), 32'd0);

    // Asynchronous reset between edges while checking.
    send(8'h82, "arst.pre");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    check("arst.bc0", byte_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_all("arst.release");

`ifdef GLIP_PATTERN_CHECKER_STALL_EN
    // With in_valid held high: 2 stalled cycles and 6 transfers per 8.
    step(1'b1, 1'b0, '0, "stall.start");
    send(8'h40, "stall.first");
    bc0 = m_bc;
    p0 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, m_exp, "stall");
      if (in_ready === 1'b0) p0++;
    end
    check("stall.low2", 32'(p0), 32'd2);
    check("stall.bc6",  byte_count, bc0 + 6);
    restart();
`else
    bc0 = 0;
    step(1'b1, 1'b0, '0, "start2");
`endif

    // Randomised stream: mostly correct, some corruption, random valid gaps,
    // occasional disable/restart.
    for (int i = 0; i < 500; i++) begin
      bit en, v;
      en = ($urandom_range(0, 39) != 0);
      v  = ($urandom_range(0, 9) < 7);
      d  = ($urandom_range(0, 9) < 8) ? m_exp : 8'($urandom);
      step(en, v, d, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_glip_pattern_checker

`default_nettype wire
